inst_ram_loader: RTL and testbench
==================================

Name: inst_ram_loader

Overview:
- Writer side of the 256x8 byte-addressed instruction RAM that the fetch stage reads at PC.
- Accepts 32-bit program words over a valid/ready handshake and writes each one as 4 big-endian bytes, one byte per cycle, starting at address 0.
- Holds the core (PC load-enable and pipeline register clears) until the program is fully loaded.
- Replaces simulation-time file precharge with a synthesizable boot path.

Parameters:
- ADDR_WIDTH, 8, RAM byte-address width.
- DEPTH, 256, RAM size in bytes; must be a multiple of 4.
- CNT_WIDTH, 7, width of word_count; must hold DEPTH/4.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- CLR  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load from address 0 (honoured in IDLE and DONE only).
- word_valid  in  1  source presents a word.
- word_data  in  32  program word.
- word_last  in  1  qualifies word_data as the final program word.
- word_ready  out  1  loader accepts a word this cycle.
- ram_we  out  1  byte write strobe to RAM.
- ram_addr  out  ADDR_WIDTH  byte address for the write.
- ram_data  out  8  byte to write.
- cpu_hold  out  1  1 = core held (PC LE low, pipeline cleared).
- busy  out  1  load in progress.
- done  out  1  load finished cleanly.
- overflow  out  1  program exceeded DEPTH bytes.
- word_count  out  CNT_WIDTH  words written since start.

Behaviour:
- Reset (CLR=0 at edge), from any state, including mid-word:
  - Enter IDLE. A partially written word is abandoned; bytes already written are not undone.
  - Outputs: word_ready=0, ram_we=0, ram_addr=0, ram_data=0, cpu_hold=1, busy=0, done=0, overflow=0, word_count=0.
  - Base pointer cleared to 0.
- States: IDLE, ACCEPT, WB0, WB1, WB2, WB3, DONE.
- IDLE:
  - Outputs held at reset values.
  - start=1: clear base pointer, word_count, done and overflow; go to ACCEPT.
- ACCEPT:
  - word_ready=1 (registered; asserted starting the cycle ACCEPT is entered). busy=1.
  - Handshake occurs when word_valid & word_ready. On handshake: capture word_data and word_last into internal registers, go to WB0.
  - No handshake: stay in ACCEPT. word_data is ignored when word_valid=0.
- WB0..WB3: word_ready=0, ram_we=1, busy=1.
  - WB0: ram_addr=base+0, ram_data=word[31:24].
  - WB1: ram_addr=base+1, ram_data=word[23:16].
  - WB2: ram_addr=base+2, ram_data=word[15:8].
  - WB3: ram_addr=base+3, ram_data=word[7:0].
  - Leaving WB3: base += 4, word_count += 1.
    - Captured last=1: go to DONE with done=1.
    - Else if the new base equals DEPTH: go to DONE with overflow=1, done=0.
    - Else: go to ACCEPT.
- Address arithmetic: base is ADDR_WIDTH+1 bits wide, so reaching DEPTH is detected and never wraps into address 0. ram_addr is base[ADDR_WIDTH-1:0] + byte offset.
- Timing:
  - Latency from handshake to the first RAM write: 1 cycle.
  - Throughput: 1 word per 5 cycles.
  - ram_we is never asserted outside WB0..WB3.
- DONE:
  - word_ready=0, ram_we=0, busy=0.
  - cpu_hold = overflow. A clean load releases the core; an overflow keeps it held.
  - start=1 restarts the load exactly as from IDLE. The core is re-held from the next cycle.
- Simultaneous events:
  - word_last on the 64th word (DEPTH=256): done=1, overflow=0. last takes priority over the full check.
  - start while busy is ignored.
  - word_valid outside ACCEPT is ignored; no data is lost, because ready is low.
- cpu_hold=1 in every state except DONE with overflow=0.

Decomposition:
- Shared package (cpu_pkg) holds the state encoding (IDLE=0, ACCEPT=1, WB0=2 .. WB3=5, DONE=6) and the big-endian byte-lane constant shared with inst_ram256x8.
- One natural sub-module: loader_byte_sel. It is a combinational 4:1 lane mux from byte index to the word slice.
- Everything else stays in inst_ram_loader.

Test Plan:
- Reset then start, one word 0xE0825005 with last=1 → writes E0@0, 82@1, 50@2, 05@3 on 4 consecutive cycles; then done=1, cpu_hold=0, word_count=1.
- Load the 9-word phase-3 program (ADD, SUBS, BNE, STRB, BLLE, 4×NOP; last on the 9th word) with word_valid held high → one word accepted every 5 cycles; bytes 0..35 match; an inst_ram256x8 read at PC=8 returns 0x1AFFFFFD.
- Source stalls (word_valid low for 3 cycles in ACCEPT) → word_ready stays 1, no RAM writes, state held; resumes normally.
- 65 words without last (DEPTH=256) → 64 words written; after the 64th, overflow=1, done=0, cpu_hold=1; 65th word never accepted (word_ready=0).
- CLR=0 asserted during WB2 of word 3 → next cycle in IDLE with all outputs at reset values; a new start reloads from address 0.
- start pulse while busy and again in DONE → ignored while busy; in DONE it clears done, word_count=0, cpu_hold=1, and accepts from address 0.

Source files
------------

// File: rtl/inst_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM boot loader.
// Holds the loader state encoding, the captured word payload and the big-endian byte-lane rule.
package inst_ram_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LANE_W         = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WB0    = 3'd2,
    ST_WB1    = 3'd3,
    ST_WB2    = 3'd4,
    ST_WB3    = 3'd5,
    ST_DONE   = 3'd6
  } load_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } word_beat_t;

  // Byte index 0 lands on the most significant lane, matching the fetch-side read of inst_ram256x8.
  localparam logic [LANE_W-1:0] BE_LANE0 = 2'd3;

  function automatic logic [LANE_W-1:0] be_lane(input logic [LANE_W-1:0] idx);
    return BE_LANE0 - idx;
  endfunction

endpackage

// File: rtl/inst_ram_loader_if.sv
// Program-word stream into the loader: valid/ready handshake with a last-word qualifier.
interface inst_ram_loader_if;
  import inst_ram_loader_pkg::*;

  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_last;
  logic              word_ready;

  modport master (output word_valid, output word_data, output word_last, input word_ready);
  modport slave  (input word_valid, input word_data, input word_last, output word_ready);

endinterface

// File: rtl/inst_ram_loader_byte_sel.sv
// 4:1 lane mux: picks the byte of a program word for a given big-endian byte index.
module loader_byte_sel
  import inst_ram_loader_pkg::*;
(
  input  logic [WORD_W-1:0] data_word,
  input  logic [LANE_W-1:0] idx,
  output logic [BYTE_W-1:0] lane_byte_c
);

  always_comb begin
    lane_byte_c = '0;
    case (be_lane(idx))
      2'd3:    lane_byte_c = data_word[31:24];
      2'd2:    lane_byte_c = data_word[23:16];
      2'd1:    lane_byte_c = data_word[15:8];
      default: lane_byte_c = data_word[7:0];
    endcase
  end

endmodule

// File: rtl/inst_ram_loader.sv
// Boot-time writer for the byte-addressed instruction RAM; streams words in as big-endian bytes
// and holds the core until a clean load completes.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned CNT_WIDTH  = 7
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  start,
  inst_ram_loader_if.slave      word_if,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BYTE_W-1:0]     ram_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  word_count
);

  // One extra bit so reaching DEPTH is visible instead of wrapping to address 0.
  localparam int unsigned BASE_W = ADDR_WIDTH + 1;

  load_state_e           state_q;
  logic [BASE_W-1:0]     base_q;
  logic [BASE_W-1:0]     base_next_c;
  word_beat_t            beat_q;
  logic                  word_ready_q;
  logic                  handshake_c;
  logic [WORD_W-1:0]     sel_word_c;
  logic [LANE_W-1:0]     sel_idx_c;
  logic [BYTE_W-1:0]     sel_byte_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;

  assign word_if.word_ready = word_ready_q;
  assign handshake_c        = (state_q == ST_ACCEPT) && word_if.word_valid && word_ready_q;
  assign base_next_c        = base_q + BASE_W'(BYTES_PER_WORD);

  // Byte to present on the next cycle: lane 0 of the incoming word, else the following lane.
  always_comb begin
    sel_word_c = beat_q.data;
    sel_idx_c  = '0;
    case (state_q)
      ST_ACCEPT: sel_word_c = word_if.word_data;
      ST_WB0:    sel_idx_c  = 2'd1;
      ST_WB1:    sel_idx_c  = 2'd2;
      ST_WB2:    sel_idx_c  = 2'd3;
      default:   sel_idx_c  = '0;
    endcase
  end

  assign sel_addr_c = base_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(sel_idx_c);

  loader_byte_sel u_byte_sel (
    .data_word   (sel_word_c),
    .idx         (sel_idx_c),
    .lane_byte_c (sel_byte_c)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      beat_q       <= '0;
      word_ready_q <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      word_count   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_ACCEPT;
            base_q       <= '0;
            word_count   <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            word_ready_q <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
          end
        end
        ST_ACCEPT: begin
          if (handshake_c) begin
            beat_q       <= '{data: word_if.word_data, last: word_if.word_last};
            state_q      <= ST_WB0;
            word_ready_q <= 1'b0;
            ram_we       <= 1'b1;
            ram_addr     <= sel_addr_c;
            ram_data     <= sel_byte_c;
          end
        end
        ST_WB0, ST_WB1, ST_WB2: begin
          state_q  <= (state_q == ST_WB0) ? ST_WB1 :
                      (state_q == ST_WB1) ? ST_WB2 : ST_WB3;
          ram_addr <= sel_addr_c;
          ram_data <= sel_byte_c;
        end
        ST_WB3: begin
          ram_we     <= 1'b0;
          ram_addr   <= '0;
          ram_data   <= '0;
          base_q     <= base_next_c;
          word_count <= word_count + CNT_WIDTH'(1);
          // A last word wins over the full check, so a program of exactly DEPTH bytes is clean.
          if (beat_q.last) begin
            state_q  <= ST_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (base_next_c == BASE_W'(DEPTH)) begin
            state_q  <= ST_DONE;
            overflow <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b1;
          end else begin
            state_q      <= ST_ACCEPT;
            word_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Randomized self-checking bench for inst_ram_loader against a word-level model of the RAM image.
module tb_inst_ram_loader;

  localparam int WORDS_MAX = 64;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       start;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [6:0] word_count;

  int checks   = 0;
  int failures = 0;

  bit [31:0] words [65];
  bit [7:0]  mem   [256];
  wr_t       exp_q [$];

  inst_ram_loader_if bus ();

  inst_ram_loader #(.ADDR_WIDTH(8), .DEPTH(256), .CNT_WIDTH(7)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .start      (start),
    .word_if    (bus),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},    32'(bus.word_ready), 32'd0);
    check({tag, "_we"},       32'(ram_we),         32'd0);
    check({tag, "_addr"},     32'(ram_addr),       32'd0);
    check({tag, "_data"},     32'(ram_data),       32'd0);
    check({tag, "_hold"},     32'(cpu_hold),       32'd1);
    check({tag, "_busy"},     32'(busy),           32'd0);
    check({tag, "_done"},     32'(done),           32'd0);
    check({tag, "_ovf"},      32'(overflow),       32'd0);
    check({tag, "_count"},    32'(word_count),     32'd0);
  endtask

  // Drives one load of n words and compares every RAM write and the end state with the model.
  task automatic run_load(input string tag, input int n, input int last_idx, input int stall_pct,
                          input int busy_start_cyc, input bit check_rate);
    int  idx, cyc, last_hs, acc, exp_acc;
    bit  finished, stall, prev_ready, prev_hs, clean;
    wr_t w;
    exp_q.delete();
    foreach (mem[i]) mem[i] = 8'h00;
    clean   = (last_idx >= 0) && (last_idx < WORDS_MAX);
    exp_acc = clean ? last_idx + 1 : WORDS_MAX;

    @(negedge CLK);
    start = 1'b1;
    bus.word_valid = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    check({tag, "_st_ready"}, 32'(bus.word_ready), 32'd1);
    check({tag, "_st_busy"},  32'(busy),           32'd1);
    check({tag, "_st_hold"},  32'(cpu_hold),       32'd1);
    check({tag, "_st_done"},  32'(done),           32'd0);
    check({tag, "_st_count"}, 32'(word_count),     32'd0);

    idx = 0; cyc = 0; last_hs = -1; acc = 0;
    finished = 1'b0; prev_ready = 1'b0; prev_hs = 1'b0;
    while (!finished && cyc < 2000) begin
      if (prev_ready && !prev_hs) check({tag, "_ready_hold"}, 32'(bus.word_ready), 32'd1);
      if (ram_we) begin
        check({tag, "_we_busy"}, 32'(busy), 32'd1);
        check({tag, "_we_pending"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check({tag, "_wr_cyc"},  32'(cyc),      32'(w.cyc));
          check({tag, "_wr_addr"}, 32'(ram_addr), 32'(w.addr));
          check({tag, "_wr_data"}, 32'(ram_data), 32'(w.data));
        end
        mem[ram_addr] = ram_data;
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check({tag, "_missing_we"}, 32'(ram_we), 32'd1);
        void'(exp_q.pop_front());
      end

      if (done || overflow) begin
        finished = 1'b1;
      end else begin
        stall          = int'($urandom_range(99)) < stall_pct;
        start          = (cyc == busy_start_cyc);
        bus.word_valid = (idx < n) && !stall;
        bus.word_data  = bus.word_valid ? words[idx] : $urandom;
        bus.word_last  = (idx == last_idx);
        prev_ready     = bus.word_ready;
        prev_hs        = bus.word_valid && bus.word_ready;
        if (prev_hs) begin
          for (int j = 0; j < 4; j++)
            exp_q.push_back('{cyc + 1 + j, 4 * acc + j, int'((words[idx] >> (8 * (3 - j))) & 32'hFF)});
          if (check_rate && last_hs >= 0) check({tag, "_rate"}, 32'(cyc - last_hs), 32'd5);
          last_hs = cyc;
          idx++;
          acc++;
        end
        @(negedge CLK);
        cyc++;
      end
    end
    start = 1'b0;
    bus.word_valid = 1'b0;

    check({tag, "_finished"}, 32'(finished),     32'd1);
    check({tag, "_accepted"}, 32'(acc),          32'(exp_acc));
    check({tag, "_done"},     32'(done),         32'(clean));
    check({tag, "_ovf"},      32'(overflow),     32'(!clean));
    check({tag, "_hold"},     32'(cpu_hold),     32'(!clean));
    check({tag, "_count"},    32'(word_count),   32'(exp_acc));
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_ready"},    32'(bus.word_ready), 32'd0);
    check({tag, "_left"},     32'(exp_q.size()), 32'd0);
    for (int k = 0; k < exp_acc; k++)
      check({tag, "_image"}, {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]}, words[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    CLR = 1'b0;
    start = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_last  = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("por");
    CLR = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset("idle");

    // Single word, last on the first beat.
    words[0] = 32'hE0825005;
    run_load("one", 1, 0, 0, -1, 1'b1);
    check("one_byte0", 32'(mem[0]), 32'hE0);
    check("one_byte3", 32'(mem[3]), 32'h05);

    // Small program with valid held high.
    words[0] = 32'hE0825005; words[1] = 32'hE2522001; words[2] = 32'h1AFFFFFD;
    words[3] = 32'hE5C12000; words[4] = 32'hDBFFFFFA;
    for (int i = 5; i < 9; i++) words[i] = 32'hE1A00000;
    run_load("prog", 9, 8, 0, -1, 1'b1);
    check("prog_pc8", {mem[8], mem[9], mem[10], mem[11]}, 32'h1AFFFFFD);

    // Random words with source stalls and a start pulse mid-load.
    for (int i = 0; i < 12; i++) words[i] = $urandom;
    run_load("stall", 12, 11, 40, 9, 1'b0);

    // Exactly DEPTH bytes with last on the final word stays clean.
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    run_load("full", 64, 63, 10, -1, 1'b0);

    // One word too many: overflow and the extra word is never taken.
    for (int i = 0; i < 65; i++) words[i] = $urandom;
    run_load("ovf", 65, -1, 0, -1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bus.word_valid = 1'b1;
      bus.word_data  = words[64];
      @(negedge CLK);
      check("ovf_ready_low", 32'(bus.word_ready), 32'd0);
      check("ovf_no_we",     32'(ram_we),         32'd0);
    end
    bus.word_valid = 1'b0;

    // Restart from an overflowed DONE.
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_load("restart", 3, 2, 20, -1, 1'b0);

    // Reset in the middle of the third word's writeback.
    @(negedge CLK);
    start = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_data  = $urandom;
    bus.word_last  = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (ram_we && ram_addr == 8'd10) found = 1'b1;
      else @(negedge CLK);
    end
    check("mid_wb2_seen", 32'(found), 32'd1);
    CLR = 1'b0;
    bus.word_valid = 1'b0;
    @(negedge CLK);
    check_reset("mid");
    CLR = 1'b1;
    words[0] = $urandom;
    run_load("reload", 1, 0, 0, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
